// File: rtl/score_counter.sv
// Score accumulator for Guitar Villains: turns hit/miss judgements into a clamped 4-bit score
// with a streak bonus, and pulses final_valid when a round ends from PLAY into FINISH.
module score_counter #(
  parameter int BONUS_STREAK = 4,
  parameter int MISS_PENALTY = 0
) (
  input  logic       clk,
  input  logic       tb_n_rst,
  input  logic [2:0] mode,
  input  logic       hit,
  input  logic       miss,
  output logic [3:0] score,
  output logic [3:0] streak,
  output logic       bonus,
  output logic       final_valid
);

  typedef enum logic [1:0] {
    MODE_IDLE,
    MODE_PLAY,
    MODE_FINISH,
    MODE_HOLD
  } mode_class_t;

  // Several raw encodings share one behaviour, so collapse them before any decisions
  function automatic mode_class_t classify(input logic [2:0] m);
    mode_class_t c;
    case (m)
      3'b000:                         c = MODE_IDLE;
      3'b001, 3'b010, 3'b011, 3'b100: c = MODE_PLAY;
      3'b101:                         c = MODE_FINISH;
      default:                        c = MODE_HOLD;
    endcase
    return c;
  endfunction

  logic [2:0]  prev_mode;
  mode_class_t cur_class;
  mode_class_t prev_class;
  logic [4:0]  score_sum;
  logic [4:0]  score_diff;
  logic [3:0]  score_next;
  logic [3:0]  streak_next;
  logic        bonus_next;
  logic        final_valid_next;

  always_ff @(posedge clk or negedge tb_n_rst) begin
    if (!tb_n_rst) begin
      score       <= 4'd0;
      streak      <= 4'd0;
      bonus       <= 1'b0;
      final_valid <= 1'b0;
      prev_mode   <= 3'b000;
    end else begin
      score       <= score_next;
      streak      <= streak_next;
      bonus       <= bonus_next;
      final_valid <= final_valid_next;
      prev_mode   <= mode;
    end
  end

  // Five-bit arithmetic: bit 4 flags overflow on the add and borrow on the subtract
  always_comb begin
    cur_class        = classify(mode);
    prev_class       = classify(prev_mode);
    score_sum        = {1'b0, score} + (bonus ? 5'd2 : 5'd1);
    score_diff       = {1'b0, score} - 5'(MISS_PENALTY);
    score_next       = score;
    streak_next      = streak;

    case (cur_class)
      MODE_IDLE: begin
        score_next  = 4'd0;
        streak_next = 4'd0;
      end
      MODE_PLAY: begin
        if (miss) begin
          streak_next = 4'd0;
          score_next  = score_diff[4] ? 4'd0 : score_diff[3:0];
        end else if (hit) begin
          score_next  = score_sum[4] ? 4'd15 : score_sum[3:0];
          streak_next = (streak == 4'd15) ? 4'd15 : streak + 4'd1;
        end
      end
      default: begin
        score_next  = score;
        streak_next = streak;
      end
    endcase

    bonus_next       = (streak_next >= 4'(BONUS_STREAK));
    final_valid_next = (cur_class == MODE_FINISH) && (prev_class == MODE_PLAY);
  end

endmodule
